// File: rtl/mix_round_engine.sv
// mix_round_engine: iterative lane-mixing datapath. NLANES lanes of WIDTH bits
// are mixed by one add / xor-shift / subtract round per clock. The number of
// rounds is set per start/done transaction.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (state lane i = i)
//   load       copy seed into the lanes (idle only)
//   seed       lane i = seed[i*WIDTH +: WIDTH]
//   start      begin a transaction (idle only); rounds sampled here
//   rounds     round count for the transaction
//   stall      hold round execution while high
//   busy       transaction in progress
//   done       one-cycle completion pulse
//   round_cnt  rounds completed in the current or last transaction
//   state      lane registers, packed like seed
module mix_round_engine #(
  parameter int unsigned NLANES = 8,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned RW     = 8,
  parameter int unsigned SHL    = 16,
  parameter int unsigned SHR    = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [NLANES*WIDTH-1:0]  seed,
  input  logic                     start,
  input  logic [RW-1:0]            rounds,
  input  logic                     stall,
  output logic                     busy,
  output logic                     done,
  output logic [RW-1:0]            round_cnt,
  output logic [NLANES*WIDTH-1:0]  state
);

  localparam int unsigned SW = NLANES * WIDTH;

  logic [RW-1:0] rounds_q;
  logic [SW-1:0] mix_c;

  // One full round. Each step updates lanes in ascending order, so a lane
  // sees the already-updated values of lower-index lanes within the same step.
  function automatic logic [SW-1:0] mix_round(input logic [SW-1:0] v);
    logic [SW-1:0] s;
    s = v;
    for (int i = 0; i < int'(NLANES); i++) begin
      s[i*WIDTH +: WIDTH] = s[i*WIDTH +: WIDTH]
                          + s[((i + NLANES - 1) % NLANES)*WIDTH +: WIDTH]
                          + WIDTH'(i);
    end
    for (int i = 0; i < int'(NLANES); i++) begin
      s[i*WIDTH +: WIDTH] = s[i*WIDTH +: WIDTH]
                          ^ (s[((i + 3) % NLANES)*WIDTH +: WIDTH] << SHL);
    end
    for (int i = 0; i < int'(NLANES); i++) begin
      s[i*WIDTH +: WIDTH] = s[i*WIDTH +: WIDTH]
                          - (s[((i + 2) % NLANES)*WIDTH +: WIDTH] >> SHR);
    end
    return s;
  endfunction

  assign mix_c = mix_round(state);

  // Control and lane registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NLANES); i++) begin
        state[i*WIDTH +: WIDTH] <= WIDTH'(i);
      end
      busy      <= 1'b0;
      done      <= 1'b0;
      round_cnt <= '0;
      rounds_q  <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (load) begin
          state <= seed;
        end
        if (start) begin
          rounds_q  <= rounds;
          round_cnt <= '0;
          // A zero-round transaction completes immediately without going busy.
          if (rounds == '0) begin
            done <= 1'b1;
          end else begin
            busy <= 1'b1;
          end
        end
      end else if (!stall) begin
        state     <= mix_c;
        round_cnt <= round_cnt + RW'(1);
        if ((round_cnt + RW'(1)) == rounds_q) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mix_round_engine.sv
module tb_mix_round_engine;

  logic         clk = 1'b0;
  logic         rst, load, start, stall;
  logic [255:0] seed;
  logic [7:0]   rounds;
  logic         busy, done;
  logic [7:0]   round_cnt;
  logic [255:0] state;

  // Small configuration used for a hand-computed round.
  logic         rst2, load2, start2, stall2;
  logic [15:0]  seed2;
  logic [7:0]   rounds2;
  logic         busy2, done2;
  logic [7:0]   round_cnt2;
  logic [15:0]  state2;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  mix_round_engine dut (
    .clk(clk), .rst(rst), .load(load), .seed(seed), .start(start),
    .rounds(rounds), .stall(stall), .busy(busy), .done(done),
    .round_cnt(round_cnt), .state(state)
  );

  mix_round_engine #(.NLANES(2), .WIDTH(8), .RW(8), .SHL(4), .SHR(2)) dut2 (
    .clk(clk), .rst(rst2), .load(load2), .seed(seed2), .start(start2),
    .rounds(rounds2), .stall(stall2), .busy(busy2), .done(done2),
    .round_cnt(round_cnt2), .state(state2)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference round written straight from the lane equations, C style.
  function automatic logic [255:0] ref_round(input logic [255:0] v);
    logic [31:0]  s [8];
    logic [255:0] r;
    for (int i = 0; i < 8; i++) s[i] = v[i*32 +: 32];
    for (int i = 0; i < 8; i++) s[i] = s[i] + s[(i + 7) % 8] + 32'(i);
    for (int i = 0; i < 8; i++) s[i] = s[i] ^ (s[(i + 3) % 8] << 16);
    for (int i = 0; i < 8; i++) s[i] = s[i] - (s[(i + 2) % 8] >> 12);
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = s[i];
    return r;
  endfunction

  function automatic logic [255:0] reset_lanes();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = 32'(i);
    return r;
  endfunction

  // Transaction-level model of the default instance.
  logic [255:0] m_s;
  bit           m_busy, m_done;
  int           m_cnt, m_r;

  always @(posedge clk) begin
    if (rst) begin
      m_s = reset_lanes(); m_busy = 0; m_done = 0; m_cnt = 0; m_r = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (!stall) begin
          m_s = ref_round(m_s);
          m_cnt++;
          if (m_cnt == m_r) begin m_busy = 0; m_done = 1; end
        end
      end else begin
        if (load) m_s = seed;
        if (start) begin
          m_r = int'(rounds); m_cnt = 0;
          if (m_r == 0) m_done = 1; else m_busy = 1;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",     state,            m_s);
      chk("busy",      256'(busy),       256'(m_busy));
      chk("done",      256'(done),       256'(m_done));
      chk("round_cnt", 256'(round_cnt),  256'(m_cnt));
    end
  end

  task automatic rand_seed(output logic [255:0] v);
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
  endtask

  // Waits for done with a cycle budget; returns cycles waited.
  task automatic wait_done(input int budget, output int cyc);
    bit seen;
    seen = 0; cyc = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  initial begin
    int cyc;
    bit seen;
    rst = 1; load = 0; start = 0; stall = 0; seed = '0; rounds = '0;
    rst2 = 1; load2 = 0; start2 = 0; stall2 = 0; seed2 = '0; rounds2 = '0;
    repeat (2) @(negedge clk);
    rst = 0; rst2 = 0;
    chk_en = 1;

    // Reset values, pinned by hand.
    for (int i = 0; i < 8; i++) chk("rst_lane", 256'(state[i*32 +: 32]), 256'(i));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_cnt",  256'(round_cnt), 256'(0));

    // Small config, one round from (0,1) gives (0x25,0x0F).
    start2 = 1; rounds2 = 8'd1;
    @(negedge clk);
    start2 = 0;
    chk("n2_busy", 256'(busy2), 256'(1));
    @(negedge clk);
    chk("n2_state", 256'(state2), 256'(16'h0F25));
    chk("n2_done",  256'(done2), 256'(1));
    chk("n2_cnt",   256'(round_cnt2), 256'(1));
    chk("n2_busy_end", 256'(busy2), 256'(0));
    @(negedge clk);
    chk("n2_done_once", 256'(done2), 256'(0));
    chk("n2_state_hold", 256'(state2), 256'(16'h0F25));

    // Zero-round transaction.
    start = 1; rounds = 8'd0;
    @(negedge clk);
    start = 0;
    chk("r0_done", 256'(done), 256'(1));
    chk("r0_busy", 256'(busy), 256'(0));
    chk("r0_lane3", 256'(state[3*32 +: 32]), 256'(3));
    @(negedge clk);
    chk("r0_done_off", 256'(done), 256'(0));

    // Ten rounds with three stalled edges: done after edge T0+13.
    start = 1; rounds = 8'd10;
    @(negedge clk);
    start = 0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      stall = (cyc >= 2 && cyc < 5);
      @(negedge clk);
      cyc++;
      if (done) seen = 1;
    end
    stall = 0;
    chk("stall_latency", 256'(cyc), 256'(13));
    chk("stall_cnt", 256'(round_cnt), 256'(10));

    // start and load while busy are ignored.
    start = 1; rounds = 8'd20;
    @(negedge clk);
    rand_seed(seed); load = 1; rounds = 8'd3;
    repeat (3) @(negedge clk);
    load = 0; start = 0;
    wait_done(40, cyc);
    chk("busy_ignore_cnt", 256'(round_cnt), 256'(20));

    // load + start together: rounds run from the seed.
    rand_seed(seed); load = 1; start = 1; rounds = 8'd5;
    @(negedge clk);
    load = 0; start = 0;
    wait_done(20, cyc);
    chk("seed_run", state, ref_round(ref_round(ref_round(ref_round(ref_round(seed))))));

    // Reset mid-transaction.
    start = 1; rounds = 8'd10;
    @(negedge clk);
    start = 0;
    cyc = 0;
    while (round_cnt != 8'd5 && cyc < 30) begin @(negedge clk); cyc++; end
    chk("mid_reached5", 256'(round_cnt), 256'(5));
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("mid_rst_state", state, reset_lanes());
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_done", 256'(done), 256'(0));
    repeat (3) begin
      @(negedge clk);
      chk("mid_no_done", 256'(done), 256'(0));
    end
    start = 1; rounds = 8'd4;
    @(negedge clk);
    start = 0;
    wait_done(20, cyc);
    chk("post_rst_cnt", 256'(round_cnt), 256'(4));

    // Randomized traffic, every cycle checked against the model.
    for (int c = 0; c < 3000; c++) begin
      rand_seed(seed);
      load   = ($urandom_range(0, 7) == 0);
      start  = ($urandom_range(0, 3) == 0);
      rounds = 8'($urandom_range(0, 12));
      stall  = ($urandom_range(0, 3) == 0);
      rst    = ($urandom_range(0, 99) == 0);
      @(negedge clk);
    end
    rst = 0; load = 0; start = 0; stall = 0;
    repeat (20) @(negedge clk);
    chk_en = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
